// File: rtl/nbody_loader.sv
// nbody_loader: streams body records into the nbody register map, then runs GO/DONE handshake.
// rst is asynchronous and active-low; every bus output is registered.
module nbody_loader #(
    parameter int ADDR_WIDTH      = 16,
    parameter int BODY_ADDR_WIDTH = 9,
    parameter int DATA_WIDTH      = 64,
    parameter int POLL_TIMEOUT    = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_start,
    input  logic [BODY_ADDR_WIDTH:0]   cfg_n_bodies,
    input  logic [DATA_WIDTH-1:0]      cfg_gap,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_WIDTH-1:0]      s_x,
    input  logic [DATA_WIDTH-1:0]      s_y,
    input  logic [DATA_WIDTH-1:0]      s_vx,
    input  logic [DATA_WIDTH-1:0]      s_vy,
    input  logic [DATA_WIDTH-1:0]      s_m,
    output logic                       m_chipselect,
    output logic                       m_write,
    output logic                       m_read,
    output logic [ADDR_WIDTH-1:0]      m_addr,
    output logic [DATA_WIDTH-1:0]      m_writedata,
    input  logic [DATA_WIDTH-1:0]      m_readdata,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);
    localparam int SW = ADDR_WIDTH - BODY_ADDR_WIDTH;
    localparam int PW = $clog2(POLL_TIMEOUT + 1);
    localparam logic [SW-1:0] SEL_GO   = SW'('h00);
    localparam logic [SW-1:0] SEL_N    = SW'('h02);
    localparam logic [SW-1:0] SEL_X    = SW'('h03);
    localparam logic [SW-1:0] SEL_Y    = SW'('h04);
    localparam logic [SW-1:0] SEL_M    = SW'('h05);
    localparam logic [SW-1:0] SEL_VX   = SW'('h06);
    localparam logic [SW-1:0] SEL_VY   = SW'('h07);
    localparam logic [SW-1:0] SEL_GAP  = SW'('h08);
    localparam logic [SW-1:0] SEL_DONE = SW'('h40);
    localparam logic [BODY_ADDR_WIDTH-1:0] I0 = '0;

    typedef enum logic [3:0] {
        IDLE, WR_N, ACCEPT, WR_X, WR_Y, WR_VX, WR_VY, WR_M,
        WR_GAP, WR_GO, POLL, POLL_WAIT, CLR_GO
    } state_t;

    state_t                     state, nstate;
    logic [BODY_ADDR_WIDTH:0]   n_q;
    logic [BODY_ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0]      gap_q, y_q, vx_q, vy_q, m_q;
    logic [PW-1:0]              poll_cnt;
    logic                       n_ok, last, wr, rd;
    logic [ADDR_WIDTH-1:0]      addr;
    logic [DATA_WIDTH-1:0]      wd;
    logic                       unused;

    assign unused = ^m_readdata[DATA_WIDTH-1:1];
    assign n_ok   = cfg_n_bodies != '0 && cfg_n_bodies <= {1'b1, {BODY_ADDR_WIDTH{1'b0}}};
    assign last   = {1'b0, idx} == n_q - (BODY_ADDR_WIDTH+1)'(1);

    // Bus values are computed for the state being entered, so each access is visible during its own state.
    always_comb begin
        nstate = state;
        wr     = 1'b0;
        rd     = 1'b0;
        addr   = '0;
        wd     = '0;
        case (state)
            IDLE: if (cfg_start && n_ok) begin
                nstate = WR_N; wr = 1'b1; addr = {SEL_N, I0}; wd = DATA_WIDTH'(cfg_n_bodies);
            end
            WR_N:   nstate = ACCEPT;
            ACCEPT: if (s_valid) begin
                nstate = WR_X; wr = 1'b1; addr = {SEL_X, idx}; wd = s_x;
            end
            WR_X:  begin nstate = WR_Y;  wr = 1'b1; addr = {SEL_Y, idx};  wd = y_q;  end
            WR_Y:  begin nstate = WR_VX; wr = 1'b1; addr = {SEL_VX, idx}; wd = vx_q; end
            WR_VX: begin nstate = WR_VY; wr = 1'b1; addr = {SEL_VY, idx}; wd = vy_q; end
            WR_VY: begin nstate = WR_M;  wr = 1'b1; addr = {SEL_M, idx};  wd = m_q;  end
            WR_M: if (last) begin
                nstate = WR_GAP; wr = 1'b1; addr = {SEL_GAP, I0}; wd = gap_q;
            end else
                nstate = ACCEPT;
            WR_GAP: begin nstate = WR_GO; wr = 1'b1; addr = {SEL_GO, I0}; wd = DATA_WIDTH'(1); end
            WR_GO:  begin nstate = POLL;  rd = 1'b1; addr = {SEL_DONE, I0}; end
            POLL:   nstate = POLL_WAIT;
            POLL_WAIT: if (m_readdata[0] || poll_cnt >= PW'(POLL_TIMEOUT)) begin
                nstate = CLR_GO; wr = 1'b1; addr = {SEL_GO, I0};
            end else begin
                nstate = POLL; rd = 1'b1; addr = {SEL_DONE, I0};
            end
            CLR_GO:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE; n_q <= '0; idx <= '0; gap_q <= '0;
            y_q <= '0; vx_q <= '0; vy_q <= '0; m_q <= '0; poll_cnt <= '0;
            m_chipselect <= 1'b0; m_write <= 1'b0; m_read <= 1'b0; m_addr <= '0; m_writedata <= '0;
            s_ready <= 1'b0; busy <= 1'b0; done <= 1'b0; err <= 1'b0;
        end else begin
            state        <= nstate;
            m_chipselect <= wr | rd;
            m_write      <= wr;
            m_read       <= rd;
            m_addr       <= addr;
            m_writedata  <= wd;
            s_ready      <= nstate == ACCEPT;
            done         <= state == POLL_WAIT && nstate == CLR_GO && m_readdata[0];
            if (state == IDLE && cfg_start) begin
                err <= !n_ok; busy <= n_ok; n_q <= cfg_n_bodies; gap_q <= cfg_gap; idx <= '0;
            end
            if (state == ACCEPT && s_valid) begin
                y_q <= s_y; vx_q <= s_vx; vy_q <= s_vy; m_q <= s_m;
            end
            if (state == WR_M && !last)
                idx <= idx + 1'b1;
            if (state == WR_GO)
                poll_cnt <= PW'(1);
            if (state == POLL_WAIT && nstate == POLL)
                poll_cnt <= poll_cnt + 1'b1;
            if (state == POLL_WAIT && nstate == CLR_GO && !m_readdata[0])
                err <= 1'b1;
            if (state == CLR_GO)
                busy <= 1'b0;
        end
    end
endmodule
